// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one instruction over a req/valid
// handshake into the IR, splits it into decode fields and strobes en1 when done.
module instr_fetch #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_fetch_pulse,
   input  logic               en_pc_pulse,
   input  logic [1:0]         pc_ctrl,
   input  logic [PC_W-1:0]    branch_target,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_valid,
   output logic [PC_W-1:0]    pc,
   output logic               en1,
   output logic [3:0]         opcode,
   output logic [1:0]         rd,
   output logic [1:0]         rs,
   output logic [7:0]         imm,
   output logic               fetch_overrun,
   output logic [1:0]         o_dbg_state
);

   // Handshake: imem_req rises with the accepted fetch pulse and holds, with
   // imem_addr frozen, until imem_valid is seen at a clock edge; imem_valid is
   // ignored whenever imem_req is low.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic               r_req, w_req_nxt;
   logic               r_en1, w_en1_nxt;
   logic               r_ovr, w_ovr_nxt;
   logic [PC_W-1:0]    r_addr, w_addr_nxt;
   logic [PC_W-1:0]    r_pc, w_pc_nxt;
   logic [INSTR_W-1:0] r_ir, w_ir_nxt;
   logic [15:0]        w_fields;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_en1   <= 1'b0;
         r_ovr   <= 1'b0;
         r_addr  <= '0;
         r_pc    <= '0;
         r_ir    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
         r_en1   <= w_en1_nxt;
         r_ovr   <= w_ovr_nxt;
         r_addr  <= w_addr_nxt;
         r_pc    <= w_pc_nxt;
         r_ir    <= w_ir_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_req;
      w_en1_nxt   = 1'b0;
      w_ovr_nxt   = r_ovr;
      w_addr_nxt  = r_addr;
      w_ir_nxt    = r_ir;
      case (r_state)
         S_IDLE: begin
            // The fetch address is the PC before any same-edge PC update.
            if (en_fetch_pulse) begin
               w_addr_nxt  = r_pc;
               w_req_nxt   = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (en_fetch_pulse) w_ovr_nxt = 1'b1;
            if (imem_valid) begin
               w_ir_nxt    = imem_rdata;
               w_req_nxt   = 1'b0;
               w_en1_nxt   = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (en_fetch_pulse) w_ovr_nxt = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_pc_nxt = r_pc;
      if (en_pc_pulse) begin
         case (pc_ctrl)
            2'b01:   w_pc_nxt = r_pc + PC_W'(1);
            2'b10:   w_pc_nxt = branch_target;
            2'b11:   w_pc_nxt = '0;
            default: w_pc_nxt = r_pc;
         endcase
      end
   end

   // Decode fields sit in the low 16 bits of the IR.
   assign w_fields      = 16'(r_ir);
   assign opcode        = w_fields[15:12];
   assign rd            = w_fields[11:10];
   assign rs            = w_fields[9:8];
   assign imm           = w_fields[7:0];

   assign imem_req      = r_req;
   assign imem_addr     = r_addr;
   assign pc            = r_pc;
   assign en1           = r_en1;
   assign fetch_overrun = r_ovr;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch, checked against a PC/IR/overrun
// reference model computed from the fetch-stage rules.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_fetch_pulse = 1'b0;
   logic        en_pc_pulse = 1'b0;
   logic [1:0]  pc_ctrl = 2'b00;
   logic [7:0]  branch_target = 8'h00;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata = 16'h0000;
   logic        imem_valid = 1'b0;
   logic [7:0]  pc;
   logic        en1;
   logic [3:0]  opcode;
   logic [1:0]  rd;
   logic [1:0]  rs;
   logic [7:0]  imm;
   logic        fetch_overrun;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;

   int          m_pc = 0;
   logic [15:0] m_ir = 16'h0000;
   logic        m_ovr = 1'b0;

   instr_fetch dut (
      .clk(clk), .rst(rst), .en_fetch_pulse(en_fetch_pulse), .en_pc_pulse(en_pc_pulse),
      .pc_ctrl(pc_ctrl), .branch_target(branch_target), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .pc(pc), .en1(en1), .opcode(opcode), .rd(rd), .rs(rs), .imm(imm),
      .fetch_overrun(fetch_overrun), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s mismatched", tag);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic int pc_rule(input int cur, input logic [1:0] ctrl, input logic [7:0] tgt);
      case (ctrl)
         2'b01:   return (cur + 1) % 256;
         2'b10:   return int'(tgt);
         2'b11:   return 0;
         default: return cur;
      endcase
   endfunction

   task automatic check_fields(input string tag);
      check({tag, "_opcode"}, opcode, m_ir[15:12]);
      check({tag, "_rd"}, rd, m_ir[11:10]);
      check({tag, "_rs"}, rs, m_ir[9:8]);
      check({tag, "_imm"}, imm, m_ir[7:0]);
   endtask

   task automatic do_pc(input logic [1:0] ctrl, input logic [7:0] tgt);
      en_pc_pulse = 1'b1; pc_ctrl = ctrl; branch_target = tgt;
      step();
      en_pc_pulse = 1'b0;
      m_pc = pc_rule(m_pc, ctrl, tgt);
      check("pc_update", pc, m_pc[7:0]);
   endtask

   // One fetch: optional same-edge PC update, wait_n idle memory cycles, an
   // optional overrun pulse injected at wait cycle ovr_at (-1 for none).
   task automatic fetch(input logic [15:0] data, input int wait_n, input logic with_pc,
                        input logic [1:0] ctrl, input logic [7:0] tgt, input int ovr_at);
      logic [7:0] exp_addr;
      exp_addr = m_pc[7:0];
      en_fetch_pulse = 1'b1;
      en_pc_pulse = with_pc; pc_ctrl = ctrl; branch_target = tgt;
      step();
      en_fetch_pulse = 1'b0; en_pc_pulse = 1'b0;
      if (with_pc) m_pc = pc_rule(m_pc, ctrl, tgt);
      check("req_rise", imem_req, 1'b1);
      check("fetch_addr", imem_addr, exp_addr);
      check("pc_after_fetch", pc, m_pc[7:0]);
      check("en1_early", en1, 1'b0);
      for (int i = 0; i < wait_n; i++) begin
         if (i == ovr_at) en_fetch_pulse = 1'b1;
         step();
         en_fetch_pulse = 1'b0;
         if (i == ovr_at) m_ovr = 1'b1;
         check("req_hold", imem_req, 1'b1);
         check("addr_hold", imem_addr, exp_addr);
         check("en1_wait", en1, 1'b0);
      end
      imem_valid = 1'b1; imem_rdata = data;
      step();
      imem_valid = 1'b0; imem_rdata = 16'($urandom);
      m_ir = data;
      check("en1_high", en1, 1'b1);
      check("req_drop", imem_req, 1'b0);
      check_fields("ir_load");
      step();
      check("en1_one_cycle", en1, 1'b0);
      check("back_idle", dbg_state, 2'd0);
      check("overrun", fetch_overrun, m_ovr);
   endtask

   initial begin
      logic [15:0] data;
      logic [1:0]  ctrl;
      logic [7:0]  tgt;

      // Reset state
      step();
      check("rst_pc", pc, 8'h00);
      check("rst_req", imem_req, 1'b0);
      check("rst_addr", imem_addr, 8'h00);
      check("rst_en1", en1, 1'b0);
      check("rst_ovr", fetch_overrun, 1'b0);
      check("rst_state", dbg_state, 2'd0);
      check_fields("rst");
      rst = 1'b0;
      step();

      // Normal IF entry, example instruction
      fetch(16'h1A05, 0, 1'b1, 2'b01, 8'h00, -1);
      check("t1_opcode", opcode, 4'h1);
      check("t1_rd", rd, 2'd2);
      check("t1_rs", rs, 2'd2);
      check("t1_imm", imm, 8'h05);
      check("t1_pc", pc, 8'h01);

      // Slow memory
      fetch(16'($urandom), 5, 1'b0, 2'b00, 8'h00, -1);

      // PC wrap, branch load, clear, hold
      do_pc(2'b10, 8'hFF);
      do_pc(2'b01, 8'h00);
      check("t3_wrap", pc, 8'h00);
      do_pc(2'b10, 8'h3C);
      check("t3_branch", pc, 8'h3C);
      do_pc(2'b00, 8'h77);
      do_pc(2'b11, 8'h55);
      check("t3_clear", pc, 8'h00);

      // Overrun while busy, then stray valid in IDLE
      check("ovr_before", fetch_overrun, 1'b0);
      fetch(16'($urandom), 3, 1'b0, 2'b00, 8'h00, 1);
      check("t4_ovr_set", fetch_overrun, 1'b1);
      imem_valid = 1'b1; imem_rdata = ~m_ir;
      step();
      imem_valid = 1'b0;
      check_fields("stray_valid");
      check("stray_en1", en1, 1'b0);
      check("stray_req", imem_req, 1'b0);
      check("ovr_sticky", fetch_overrun, 1'b1);

      // Randomized fetches and PC operations
      for (int n = 0; n < 40; n++) begin
         data = 16'($urandom);
         ctrl = 2'($urandom_range(0, 3));
         tgt  = 8'($urandom);
         if ($urandom_range(0, 2) == 0) do_pc(ctrl, tgt);
         else fetch(data, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                    ctrl, tgt, $urandom_range(0, 9) == 0 ? 0 : -1);
      end

      // Reset during REQ, then a late response
      do_pc(2'b10, 8'h42);
      en_fetch_pulse = 1'b1;
      step();
      en_fetch_pulse = 1'b0;
      check("t5_req_up", imem_req, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("t5_req_async_drop", imem_req, 1'b0);
      step();
      rst = 1'b0;
      m_pc = 0; m_ir = 16'h0000; m_ovr = 1'b0;
      #1;
      check("t5_state", dbg_state, 2'd0);
      check("t5_pc", pc, 8'h00);
      check_fields("t5_ir");
      imem_valid = 1'b1; imem_rdata = 16'hBEEF;
      step();
      imem_valid = 1'b0;
      check_fields("t5_late_valid");
      check("t5_late_en1", en1, 1'b0);
      check("t5_late_req", imem_req, 1'b0);
      check("t5_late_state", dbg_state, 2'd0);
      check("t5_ovr", fetch_overrun, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
